button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a level change.
REQ-002 Parameter HOLD_CYCLES, default 1000: accepted-press duration on lap_btn that turns a lap press into a clear request; SHALL exceed DEBOUNCE_CYCLES.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 res  input  1  reset, synchronous, active-high.
REQ-005 start_btn  input  1  raw asynchronous start/stop button, active-high, may bounce.
REQ-006 lap_btn  input  1  raw asynchronous lap button, active-high, may bounce.
REQ-007 start_stop  output  1  one-cycle impulse per accepted start_btn press.
REQ-008 lap_time  output  1  one-cycle impulse per accepted short lap_btn press.
REQ-009 clear  output  1  one-cycle impulse per accepted long lap_btn press.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each channel SHALL hold a debounced level and a counter: counter resets to 0 on any cycle where the synchronized sample equals the debounced level, else increments; when it reaches DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
REQ-012 Latency from a clean raw edge to the debounced level change SHALL be exactly 2 + DEBOUNCE_CYCLES clock cycles.
REQ-013 start_stop SHALL pulse high for exactly one cycle, in the cycle after start debounced level rises 0->1; no pulse on release.
REQ-014 Lap channel SHALL run FSM with states IDLE, HELD, LONG.
REQ-015 IDLE -> HELD on debounced rise; hold counter cleared.
REQ-016 HELD: hold counter increments each cycle; at HOLD_CYCLES-1 -> LONG with one-cycle clear pulse; on debounced fall before that -> IDLE with one-cycle lap_time pulse.
REQ-017 LONG: no further pulses; on debounced fall -> IDLE; lap_time SHALL NOT pulse for that press.
REQ-018 Hold counter SHALL saturate, never wrap; width clog2(HOLD_CYCLES).
REQ-019 Bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no pulse and no level change.
REQ-020 Channels independent: simultaneous presses SHALL yield start_stop and lap_time/clear pulses in the same cycle if timing coincides.
REQ-021 Outputs SHALL be registered; at most one of lap_time, clear high in any cycle.
REQ-022 Button held high through reset release SHALL be treated as a new press once debounced (start_stop pulses).

Reset
REQ-023 While res high: synchronizers, debounced levels, counters cleared to 0; lap FSM IDLE; start_stop, lap_time, clear = 0 on the next edge.
REQ-024 Reset asserted mid-press or mid-hold SHALL abort without emitting any pulse.

Structure
REQ-025 Shared package SHALL hold lap FSM state encoding (IDLE=0, HELD=1, LONG=2, 2 bits) and default DEBOUNCE_CYCLES/HOLD_CYCLES constants.
REQ-026 One sub-module debounce_channel (synchronizer + debounce counter + level), instantiated twice.
REQ-027 Output pulses feed the existing start/stop and lap toggle logic directly; no further edge detection required downstream.

Verification (DEBOUNCE_CYCLES=16, HOLD_CYCLES=100 unless noted)
REQ-028 Clean start_btn 0->1 at cycle 0, held 50 cycles -> start_stop high exactly cycle 19 only; release -> no pulse.
REQ-029 start_btn toggling every 5 cycles for 60 cycles then low -> start_stop never high; debounced level stays 0.
REQ-030 lap_btn high 40 cycles then low -> lap_time single pulse ~19 cycles after release edge; clear never high.
REQ-031 lap_btn high 300 cycles -> clear single pulse at 2+16+100 cycles after press; lap_time never high, also after release.
REQ-032 res asserted at cycle 60 of a 150-cycle lap press, released at 65, button still held -> no clear, no lap_time pulse before reset; afterwards FSM restarts, press re-accepted per REQ-022.
REQ-033 start_btn and lap_btn short press rising same cycle, both released same cycle -> start_stop pulse on press, lap_time pulse on release, no other pulses.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared lap FSM encoding and default timing constants
// Exports:
//   lap_state_t               lap FSM state (IDLE=0, HELD=1, LONG=2)
//   DEFAULT_DEBOUNCE_CYCLES   stable samples needed to accept a level change
//   DEFAULT_HOLD_CYCLES       accepted-press length that turns a lap press into a clear
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } lap_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_HOLD_CYCLES     = 1000;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// rtl/button_conditioner_debounce_channel.sv - 2-flop synchronizer plus counter-based debouncer
// Ports:
//   clk    system clock
//   res    synchronous active-high reset
//   raw    asynchronous, possibly bouncing button input
//   level  debounced level, changes 2 + DEBOUNCE_CYCLES cycles after a clean raw edge
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic res,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_out;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (res) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
            level     <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
            if (sync_out == level) begin
                // Any agreeing sample restarts the stability window, so bounce never accumulates.
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounces start and lap buttons into start_stop, lap_time and clear impulses
// Ports:
//   clk         system clock
//   res         synchronous active-high reset
//   start_btn   raw start/stop button, active-high, may bounce
//   lap_btn     raw lap button, active-high, may bounce
//   start_stop  one-cycle impulse per accepted start_btn press
//   lap_time    one-cycle impulse per accepted short lap_btn press (emitted on release)
//   clear       one-cycle impulse when a lap_btn press lasts HOLD_CYCLES accepted cycles
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
    input  logic clk,
    input  logic res,
    input  logic start_btn,
    input  logic lap_btn,
    output logic start_stop,
    output logic lap_time,
    output logic clear
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

    logic start_level;
    logic start_level_d;
    logic lap_level;

    lap_state_t    state;
    lap_state_t    state_next;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_cnt_next;
    logic [HW-1:0] hold_inc;
    logic          lap_time_next;
    logic          clear_next;

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start (
        .clk  (clk),
        .res  (res),
        .raw  (start_btn),
        .level(start_level)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lap (
        .clk  (clk),
        .res  (res),
        .raw  (lap_btn),
        .level(lap_level)
    );

    // Saturating increment: the counter must never wrap back and re-arm a clear.
    assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        lap_time_next = 1'b0;
        clear_next    = 1'b0;
        case (state)
            IDLE: begin
                if (lap_level) begin
                    state_next    = HELD;
                    hold_cnt_next = '0;
                end
            end
            HELD: begin
                if (!lap_level) begin
                    // Released before the hold threshold: a short press.
                    state_next    = IDLE;
                    lap_time_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_inc;
                    if (hold_inc == HOLD_MAX) begin
                        state_next = LONG;
                        clear_next = 1'b1;
                    end
                end
            end
            LONG: begin
                // The press already produced its clear; release is silent.
                if (!lap_level) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            start_level_d <= 1'b0;
            start_stop    <= 1'b0;
            lap_time      <= 1'b0;
            clear         <= 1'b0;
        end else begin
            state         <= state_next;
            hold_cnt      <= hold_cnt_next;
            start_level_d <= start_level;
            // Rising edge of the debounced level only; release produces nothing.
            start_stop    <= start_level & ~start_level_d;
            lap_time      <= lap_time_next;
            clear         <= clear_next;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner against a timestamp reference model
module tb_button_conditioner;

    localparam int D = 16;
    localparam int H = 100;

    logic clk       = 1'b0;
    logic res       = 1'b1;
    logic start_btn = 1'b0;
    logic lap_btn   = 1'b0;
    logic start_stop;
    logic lap_time;
    logic clear;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clk       (clk),
        .res       (res),
        .start_btn (start_btn),
        .lap_btn   (lap_btn),
        .start_stop(start_stop),
        .lap_time  (lap_time),
        .clear     (clear)
    );

    typedef struct {
        int       cyc;
        bit [2:0] v;   // {clear, lap_time, start_stop}
    } exp_t;

    exp_t exp_q[$];
    int   edge_n      = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   res_seen    = 1'b0;

    // Reference model: each raw input reaches the debouncer two edges late; the
    // debounced level flips after D consecutive disagreeing samples. Pulses are
    // derived from the edge numbers at which the debounced levels changed.
    bit       m_pipe0 [2];
    bit       m_pipe1 [2];
    bit       m_level [2];
    int       m_run   [2];
    int       m_rise  [2];
    int       m_fall  [2];
    bit       m_pressed;
    bit       m_long;
    bit       m_raw   [2];
    bit       m_samp;
    bit [2:0] m_v;

    initial begin
        for (int c = 0; c < 2; c++) begin
            m_pipe0[c] = 1'b0;
            m_pipe1[c] = 1'b0;
            m_level[c] = 1'b0;
            m_run[c]   = 0;
            m_rise[c]  = -100;
            m_fall[c]  = -100;
        end
        m_pressed = 1'b0;
        m_long    = 1'b0;
        forever begin
            @(posedge clk);
            edge_n++;
            m_raw[0] = start_btn;
            m_raw[1] = lap_btn;
            if (res) begin
                for (int c = 0; c < 2; c++) begin
                    m_pipe0[c] = 1'b0;
                    m_pipe1[c] = 1'b0;
                    m_level[c] = 1'b0;
                    m_run[c]   = 0;
                    m_rise[c]  = -100;
                    m_fall[c]  = -100;
                end
                m_pressed = 1'b0;
                m_long    = 1'b0;
            end else begin
                m_v = 3'b000;
                if (m_rise[0] == edge_n - 1) m_v[0] = 1'b1;
                if (m_pressed) begin
                    if (m_fall[1] == edge_n - 1) begin
                        if (!m_long) m_v[1] = 1'b1;
                        m_pressed = 1'b0;
                    end else if (!m_long && edge_n == m_rise[1] + H) begin
                        m_v[2] = 1'b1;
                        m_long = 1'b1;
                    end
                end
                for (int c = 0; c < 2; c++) begin
                    m_samp     = m_pipe1[c];
                    m_pipe1[c] = m_pipe0[c];
                    m_pipe0[c] = m_raw[c];
                    if (m_samp != m_level[c]) begin
                        m_run[c]++;
                        if (m_run[c] == D) begin
                            m_level[c] = ~m_level[c];
                            m_run[c]   = 0;
                            if (m_level[c]) m_rise[c] = edge_n;
                            else            m_fall[c] = edge_n;
                            if (c == 1 && m_level[c]) begin
                                m_pressed = 1'b1;
                                m_long    = 1'b0;
                            end
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
                if (m_v != 3'b000) exp_q.push_back('{cyc: edge_n, v: m_v});
            end
            res_seen = res;
        end
    end

    // Monitor: every cycle the DUT outputs are compared with the scoreboard entry
    // for that edge, or with all-zero when none is queued.
    logic [2:0] dv;
    bit   [2:0] ev;

    initial begin
        forever begin
            @(negedge clk);
            if (edge_n > 0) begin
                dv = {clear, lap_time, start_stop};
                if (res_seen) begin
                    vectors++;
                    if (dv !== 3'b000) begin
                        miscompares++;
                        $display("FAIL reset_outputs @%0d: got %b, expected 000", edge_n, dv);
                    end
                end else begin
                    while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL missed_pulse @%0d: expected %b never compared", exp_q[0].cyc, exp_q[0].v);
                        void'(exp_q.pop_front());
                    end
                    ev = 3'b000;
                    if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
                        ev = exp_q[0].v;
                        void'(exp_q.pop_front());
                    end
                    vectors++;
                    if (dv !== ev) begin
                        miscompares++;
                        $display("FAIL pulses @%0d {clear,lap_time,start_stop}: got %b, expected %b", edge_n, dv, ev);
                    end
                end
            end
        end
    end

    task automatic drive(input bit r, input bit s, input bit l, input int n);
        repeat (n) begin
            @(negedge clk);
            res       = r;
            start_btn = s;
            lap_btn   = l;
        end
    endtask

    int s_left;
    int l_left;
    bit s_v;
    bit l_v;
    bit r_v;

    initial begin
        drive(1, 0, 0, 3);
        drive(0, 0, 0, 5);

        // Clean start press held 50 cycles, then release.
        drive(0, 1, 0, 50);
        drive(0, 0, 0, 40);

        // Start button toggling every 5 cycles: pure bounce.
        for (int i = 0; i < 12; i++) drive(0, (i % 2) == 0, 0, 5);
        drive(0, 0, 0, 30);

        // Short lap press.
        drive(0, 0, 1, 40);
        drive(0, 0, 0, 40);

        // Long lap press.
        drive(0, 0, 1, 300);
        drive(0, 0, 0, 40);

        // Reset in the middle of a lap hold, button kept pressed through release of reset.
        drive(0, 0, 1, 60);
        drive(1, 0, 1, 5);
        drive(0, 0, 1, 85);
        drive(0, 0, 0, 40);

        // Simultaneous short presses on both buttons.
        drive(0, 1, 1, 40);
        drive(0, 0, 0, 40);

        // Start button held through reset release.
        drive(0, 1, 0, 30);
        drive(1, 1, 0, 5);
        drive(0, 1, 0, 30);
        drive(0, 0, 0, 30);

        // Debounce threshold: D-1 samples rejected, D samples accepted.
        drive(0, 1, 0, D - 1);
        drive(0, 0, 0, 30);
        drive(0, 1, 0, D);
        drive(0, 0, 0, 30);

        // Hold threshold: H-1 accepted cycles is short, H accepted cycles is long.
        drive(0, 0, 1, H - 1);
        drive(0, 0, 0, 30);
        drive(0, 0, 1, H);
        drive(0, 0, 0, 30);

        // Randomized bouncing and presses on both channels with rare resets.
        s_left = 0;
        l_left = 0;
        s_v    = 1'b0;
        l_v    = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (s_left == 0) begin
                s_v    = ~s_v;
                s_left = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20))
                                                    : int'($urandom_range(10, 160));
            end
            if (l_left == 0) begin
                l_v    = ~l_v;
                l_left = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20))
                                                    : int'($urandom_range(10, 180));
            end
            r_v = ($urandom_range(0, 999) == 0);
            drive(r_v, s_v, l_v, 1);
            s_left--;
            l_left--;
        end
        drive(0, 0, 0, 60);

        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected pulses, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
